// File: rtl/alu_seq.sv
// Registered ALU behind a valid/ready handshake. Single-cycle ops finish at accept.
// MUL and the shifts iterate one bit per cycle in BUSY.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic [3:0]       sel,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             is_equal,
    output logic             zero
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

    localparam int CW = SHW + 1;

    // Arithmetic opcodes (mode = 0)
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ADC = 4'd2, OP_INC = 4'd3,
                           OP_DEC = 4'd4, OP_NEG = 4'd5, OP_MUL = 4'd6, OP_SHL = 4'd7,
                           OP_SHR = 4'd8, OP_SRA = 4'd9;
    // Logical opcodes (mode = 1)
    localparam logic [3:0] LG_AND  = 4'd0, LG_OR   = 4'd1, LG_XOR   = 4'd2, LG_NOT  = 4'd3,
                           LG_NAND = 4'd4, LG_NOR  = 4'd5, LG_XNOR  = 4'd6, LG_PASA = 4'd7,
                           LG_PASB = 4'd8, LG_ANDN = 4'd9, LG_ORN   = 4'd10;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, lo_q, hi_q;
    logic [3:0]       sel_q;
    logic [CW-1:0]    cnt_q;
    logic             eq_q;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cout_q, cout_d, is_equal_q, is_equal_d, zero_q;
    logic             load_res;

    logic             accept, is_mul, is_shift, go_busy;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] sc_f;
    logic             sc_c;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_a;
    logic             step_bit;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign amt       = b[SHW-1:0];
    assign is_mul    = !mode && (sel == OP_MUL);
    assign is_shift  = !mode && ((sel == OP_SHL) || (sel == OP_SHR) || (sel == OP_SRA));
    assign go_busy   = is_mul || (is_shift && (amt != '0));

    assign f        = f_q;
    assign cout     = cout_q;
    assign is_equal = is_equal_q;
    assign zero     = zero_q;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        sc_f = '0;
        sc_c = 1'b0;
        if (!mode) begin
            case (sel)
                OP_ADD: {sc_c, sc_f} = {1'b0, a} + {1'b0, b};
                OP_SUB: begin sc_f = a - b; sc_c = (a >= b); end
                OP_ADC: {sc_c, sc_f} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                OP_INC: {sc_c, sc_f} = {1'b0, a} + (WIDTH+1)'(1);
                OP_DEC: begin sc_f = a - WIDTH'(1); sc_c = (a != '0); end
                OP_NEG: begin sc_f = -a; sc_c = (a != '0); end
                OP_SHL, OP_SHR, OP_SRA: sc_f = a;  // only reached with a zero shift amount
                default: ;
            endcase
        end else begin
            case (sel)
                LG_AND:  sc_f = a & b;
                LG_OR:   sc_f = a | b;
                LG_XOR:  sc_f = a ^ b;
                LG_NOT:  sc_f = ~a;
                LG_NAND: sc_f = ~(a & b);
                LG_NOR:  sc_f = ~(a | b);
                LG_XNOR: sc_f = ~(a ^ b);
                LG_PASA: sc_f = a;
                LG_PASB: sc_f = b;
                LG_ANDN: sc_f = a & ~b;
                LG_ORN:  sc_f = a | ~b;
                default: ;
            endcase
        end
    end

    // One iteration: multiply adds the multiplicand when the current multiplier bit is set.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
        step_a   = opa_q;
        step_bit = 1'b0;
        case (sel_q)
            OP_SHL: begin step_a = {opa_q[WIDTH-2:0], 1'b0};         step_bit = opa_q[WIDTH-1]; end
            OP_SHR: begin step_a = {1'b0, opa_q[WIDTH-1:1]};         step_bit = opa_q[0];       end
            OP_SRA: begin step_a = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]}; step_bit = opa_q[0];     end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        load_res   = 1'b0;
        f_d        = sc_f;
        cout_d     = sc_c;
        is_equal_d = (a == b);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (go_busy) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        load_res = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d    = ST_DONE;
                    load_res   = 1'b1;
                    is_equal_d = eq_q;
                    if (sel_q == OP_MUL) begin
                        f_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
                        cout_d = |mul_sum[WIDTH:1];
                    end else begin
                        f_d    = step_a;
                        cout_d = step_bit;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            eq_q       <= 1'b0;
            f_q        <= '0;
            cout_q     <= 1'b0;
            is_equal_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            if (accept) begin
                opa_q <= a;
                lo_q  <= b;
                hi_q  <= '0;
                sel_q <= sel;
                eq_q  <= (a == b);
                cnt_q <= is_mul ? CW'(WIDTH) : {1'b0, amt};
            end else if (state_q == ST_BUSY) begin
                cnt_q <= cnt_q - CW'(1);
                if (sel_q == OP_MUL) {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
                else                 opa_q        <= step_a;
            end
            if (load_res) begin
                f_q        <= f_d;
                cout_q     <= cout_d;
                is_equal_q <= is_equal_d;
                zero_q     <= (f_d == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): a vector table plus hand-written sequences
// for backpressure and reset during a multiply.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [7:0] a, b;
    logic       mode;
    logic [3:0] sel;
    logic       cin;
    logic       out_valid, out_ready;
    logic [7:0] f;
    logic       cout, is_equal, zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       m;
        logic [3:0] s;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] f;
        logic       co;
        logic       z;
        logic       eq;
        int         lat;
    } vec_t;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .sel(sel), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .cout(cout), .is_equal(is_equal), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [3:0] s, input logic [7:0] va, vb,
                                input logic c, input logic [7:0] ef, input logic eco, ez, eeq,
                                input int lat);
        vec_t v;
        v.m = m; v.s = s; v.a = va; v.b = vb; v.c = c;
        v.f = ef; v.co = eco; v.z = ez; v.eq = eeq; v.lat = lat;
        return v;
    endfunction

    // Presents an op and returns #1 after the accepting edge.
    task automatic start_op(input logic m, input logic [3:0] s, input logic [7:0] va, vb,
                            input logic c);
        int guard = 0;
        @(negedge clk);
        mode = m; sel = s; a = va; b = vb; cin = c; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready before accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy);
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            @(posedge clk);
            #1 lat++;
        end
        check("out_valid within bound", out_valid, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("in_ready after consume", in_ready, 1);
    endtask

    vec_t vt[28];

    initial begin
        int lat, busy, bad;

        vt[0]  = mk(0, 4'd0,  8'hF0, 8'h20, 1, 8'h10, 1, 0, 0, 1);  // ADD, cin ignored
        vt[1]  = mk(0, 4'd1,  8'h5A, 8'h5A, 0, 8'h00, 1, 1, 1, 1);  // SUB equal
        vt[2]  = mk(0, 4'd2,  8'hFF, 8'h00, 1, 8'h00, 1, 1, 0, 1);  // ADC
        vt[3]  = mk(0, 4'd6,  8'h0F, 8'h11, 0, 8'hFF, 0, 0, 0, 9);  // MUL
        vt[4]  = mk(0, 4'd6,  8'h10, 8'h10, 0, 8'h00, 1, 1, 1, 9);  // MUL overflow
        vt[5]  = mk(0, 4'd9,  8'h80, 8'h03, 0, 8'hF0, 0, 0, 0, 4);  // SRA 3
        vt[6]  = mk(0, 4'd7,  8'h81, 8'h01, 0, 8'h02, 1, 0, 0, 2);  // SHL 1
        vt[7]  = mk(0, 4'd8,  8'hA5, 8'h08, 0, 8'hA5, 0, 0, 0, 1);  // SHR amount 0
        vt[8]  = mk(0, 4'd3,  8'hFF, 8'h00, 0, 8'h00, 1, 1, 0, 1);  // INC wrap
        vt[9]  = mk(0, 4'd4,  8'h00, 8'h00, 0, 8'hFF, 0, 0, 1, 1);  // DEC of 0
        vt[10] = mk(0, 4'd5,  8'h01, 8'h00, 0, 8'hFF, 1, 0, 0, 1);  // NEG
        vt[11] = mk(0, 4'd1,  8'h10, 8'h20, 0, 8'hF0, 0, 0, 0, 1);  // SUB borrow
        vt[12] = mk(1, 4'd0,  8'hCC, 8'hAA, 0, 8'h88, 0, 0, 0, 1);  // AND
        vt[13] = mk(1, 4'd2,  8'hAA, 8'hFF, 0, 8'h55, 0, 0, 0, 1);  // XOR
        vt[14] = mk(1, 4'd3,  8'h0F, 8'h00, 0, 8'hF0, 0, 0, 0, 1);  // NOT
        vt[15] = mk(1, 4'd4,  8'hFF, 8'hFF, 0, 8'h00, 0, 1, 1, 1);  // NAND
        vt[16] = mk(1, 4'd10, 8'h00, 8'h0F, 0, 8'hF0, 0, 0, 0, 1);  // ORN
        vt[17] = mk(1, 4'd8,  8'h12, 8'h34, 0, 8'h34, 0, 0, 0, 1);  // PASS b
        vt[18] = mk(0, 4'd12, 8'h12, 8'h34, 1, 8'h00, 0, 1, 0, 1);  // reserved arith
        vt[19] = mk(1, 4'd13, 8'h12, 8'h34, 0, 8'h00, 0, 1, 0, 1);  // reserved logic
        vt[20] = mk(0, 4'd8,  8'h88, 8'h04, 0, 8'h08, 1, 0, 0, 5);  // SHR 4
        vt[21] = mk(0, 4'd9,  8'h7F, 8'h07, 0, 8'h00, 1, 1, 0, 8);  // SRA 7
        vt[22] = mk(0, 4'd6,  8'hFF, 8'hFF, 0, 8'h01, 1, 0, 1, 9);  // MUL max
        vt[23] = mk(1, 4'd6,  8'h0F, 8'h0F, 0, 8'hFF, 0, 0, 1, 1);  // XNOR
        vt[24] = mk(1, 4'd7,  8'h3C, 8'h00, 0, 8'h3C, 0, 0, 0, 1);  // PASS a
        vt[25] = mk(1, 4'd1,  8'h50, 8'h05, 0, 8'h55, 0, 0, 0, 1);  // OR
        vt[26] = mk(1, 4'd5,  8'hF0, 8'h0F, 0, 8'h00, 0, 1, 0, 1);  // NOR
        vt[27] = mk(1, 4'd9,  8'hF3, 8'h30, 0, 8'hC3, 0, 0, 0, 1);  // ANDN

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; mode = 1'b0; sel = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready",  in_ready,  1);
        check("reset out_valid", out_valid, 0);
        check("reset f",         f,         0);
        check("reset cout",      cout,      0);
        check("reset is_equal",  is_equal,  0);
        check("reset zero",      zero,      0);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            start_op(vt[i].m, vt[i].s, vt[i].a, vt[i].b, vt[i].c);
            wait_done(lat, busy);
            check($sformatf("v%0d f", i),        f,        vt[i].f);
            check($sformatf("v%0d cout", i),     cout,     vt[i].co);
            check($sformatf("v%0d zero", i),     zero,     vt[i].z);
            check($sformatf("v%0d is_equal", i), is_equal, vt[i].eq);
            check($sformatf("v%0d latency", i),  lat,      vt[i].lat);
            check($sformatf("v%0d busy", i),     busy,     vt[i].lat - 1);
            consume();
        end

        // Backpressure: result held, in_valid pulses ignored while DONE.
        start_op(0, 4'd0, 8'h33, 8'h44, 0);
        wait_done(lat, busy);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a = 8'h01; b = 8'h01; sel = 4'd0; mode = 1'b0; in_valid = (k % 2 == 0);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d f", k),         f,         8'h77);
            check($sformatf("bp%0d cout", k),      cout,      0);
            check($sformatf("bp%0d out_valid", k), out_valid, 1);
            check($sformatf("bp%0d in_ready", k),  in_ready,  0);
        end
        in_valid = 1'b0;
        consume();
        check("bp release out_valid", out_valid, 0);
        check("bp release f held",    f,         8'h77);

        // Reset during the 4th BUSY cycle of a multiply.
        start_op(0, 4'd6, 8'h03, 8'h03, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort f",         f,         0);
        check("abort cout",      cout,      0);
        check("abort is_equal",  is_equal,  0);
        check("abort out_valid", out_valid, 0);
        check("abort in_ready",  in_ready,  1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (out_valid) bad = 1;
        end
        check("no result after abort", bad, 0);

        start_op(1, 4'd2, 8'hAA, 8'hFF, 0);
        wait_done(lat, busy);
        check("post-abort XOR f",   f,   8'h55);
        check("post-abort latency", lat, 1);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Operands are WIDTH bits wide and are accepted through a valid/ready handshake. Results are held in an output register until consumed.
- Adds multi-cycle operations: a shift-add multiply and serial shifts by a variable amount.
- Sits between the operand register file and the writeback stage of the lab datapath.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range 4..32; must be a power of two.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts.
- mode  in  1  0 = arithmetic, 1 = logical.
- sel  in  4  operation select.
- cin  in  1  carry in, active-high, used by ADC only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- f  out  WIDTH  result.
- cout  out  1  carry/flag, defined per operation below.
- is_equal  out  1  a==b, sampled at accept.
- zero  out  1  f==0.

Behaviour:
- One clock: clk. Reset rst is asynchronous, active-high.
- Reset:
  - state=IDLE.
  - f, cout, is_equal, zero, out_valid all 0; internal accumulators 0.
  - in_ready=1 while in reset and after it.
- Accept: occurs on a rising edge with in_valid && in_ready. The block captures a, b, mode, sel and cin, and latches is_equal=(a==b).
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> DONE on accept of a single-cycle op. Latency is 1: out_valid rises at the edge after accept.
  - IDLE -> BUSY on accept of MUL, or of a shift with amount != 0.
  - IDLE -> DONE for a shift with amount == 0: f=a, cout=0.
  - BUSY -> DONE when the iteration counter reaches its terminal count.
  - DONE -> IDLE on out_valid && out_ready. in_ready stays low in DONE, so there is no same-cycle re-accept.
- mode=0 (arithmetic) operations:
  - sel 0 ADD: f=a+b, cout=carry out.
  - sel 1 SUB: f=a-b, cout=1 if a>=b (unsigned), no borrow.
  - sel 2 ADC: f=a+b+cin, cout=carry out.
  - sel 3 INC: f=a+1, cout=carry out.
  - sel 4 DEC: f=a-1, cout=1 if a!=0.
  - sel 5 NEG: f=-a (two's complement), cout=(a!=0).
  - sel 6 MUL: unsigned shift-add, one bit of b per cycle, exactly WIDTH cycles in BUSY.
    - f = low WIDTH bits of the product.
    - cout = 1 if the high half is nonzero.
  - sel 7 SHL: shifts a left by b[SHW-1:0], one bit per cycle.
  - sel 8 SHR: logical right shift, one bit per cycle.
  - sel 9 SRA: arithmetic right shift, one bit per cycle.
  - For SHL/SHR/SRA: BUSY lasts exactly the shift amount in cycles, and cout = the last bit shifted out.
  - sel 10..15 reserved: f=0, cout=0, latency 1.
- mode=1 (logical) operations, all with cout=0 and latency 1:
  - sel 0 AND, 1 OR, 2 XOR, 3 NOT a, 4 NAND, 5 NOR, 6 XNOR, 7 PASS a, 8 PASS b, 9 ANDN (a&~b), 10 ORN (a|~b).
  - sel 11..15: f=0.
- Result register behaviour:
  - zero=(f==0), computed from the value being loaded into f.
  - f, cout, is_equal and zero change only when entering DONE. They are held stable while out_valid=1 && out_ready=0.
  - Outputs keep their last values in IDLE and BUSY. out_valid=0 in those states.
- Simultaneous events: in_valid while BUSY or DONE is ignored; the operand must be held by the producer.
- Reset asserted mid-BUSY: the operation is aborted immediately and all outputs return to reset values. No result is produced.
- All arithmetic is modulo 2^WIDTH. Operands are unsigned except for SRA sign-fill and NEG.

Test Plan:
1. Reset and ADD: rst pulse, then ADD a=8'hF0, b=8'h20 -> in_ready=1 after reset; out_valid one cycle after accept; f=8'h10, cout=1, zero=0, is_equal=0.
2. SUB equality: SUB a=b=8'h5A -> f=8'h00, cout=1, zero=1, is_equal=1; ADC a=8'hFF, b=8'h00, cin=1 -> f=8'h00, cout=1.
3. MUL: a=8'h0F, b=8'h11 -> in_ready low for exactly 8 BUSY cycles, then f=8'hFF, cout=0; a=8'h10, b=8'h10 -> f=8'h00, cout=1.
4. Shifts:
   - SRA a=8'h80, b=3 -> 3 BUSY cycles, f=8'hF0, cout=0.
   - SHL a=8'h81, b=1 -> f=8'h02, cout=1.
   - SHR with b=8 (amount field = 0) -> f=a, latency 1.
5. Backpressure: hold out_ready=0 for 5 cycles after DONE -> f/cout stable; in_valid pulses during this time are ignored; after out_ready=1, in_ready returns the next cycle.
6. Reset mid-MUL: assert rst on the 4th BUSY cycle -> out_valid never rises for that op; f=0; next accepted op (logical XOR a=8'hAA, b=8'hFF) -> f=8'h55.
